// File: rtl/uart_pkg.sv
// Shared UART receiver types, register offsets and defaults.
// Build option: UART_RX_FIFO_EN selects an 8-entry receive FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  localparam logic [31:0] UART_REG_DATA   = 32'd0;
  localparam logic [31:0] UART_REG_STATUS = 32'd4;

  localparam int ST_AVAIL    = 0;
  localparam int ST_OVERRUN  = 1;
  localparam int ST_FRAMEERR = 2;

  localparam int BAUD_DIVIDER_DEFAULT = 1301;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: holding register (DEPTH=1) or circular FIFO.
// A simultaneous pop frees space before the push is accepted.
module uart_rx_fifo #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  generate
    if (DEPTH == 1) begin : g_reg
      logic [7:0] r_data;
      logic       r_full;
      logic       w_pop;
      logic       w_push;

      assign w_pop  = pop & r_full;
      assign w_push = push & (~r_full | w_pop);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_data <= 8'd0;
          r_full <= 1'b0;
        end else begin
          if (w_push) r_data <= din;
          if (w_push) r_full <= 1'b1;
          else if (w_pop) r_full <= 1'b0;
        end
      end

      assign dout  = r_data;
      assign empty = ~r_full;
      assign full  = r_full;
    end else begin : g_ring
      localparam int AW = $clog2(DEPTH);
      localparam logic [AW:0] W_DEPTH = (AW+1)'(DEPTH);

      logic [7:0]  r_mem [DEPTH];
      logic [AW-1:0] r_wp;
      logic [AW-1:0] r_rp;
      logic [AW:0]   r_cnt;
      logic          w_pop;
      logic          w_push;

      assign w_pop  = pop & (r_cnt != '0);
      assign w_push = push & ((r_cnt != W_DEPTH) | w_pop);

      always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_wp  <= '0;
          r_rp  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push) r_wp <= r_wp + 1'b1;
          if (w_pop)  r_rp <= r_rp + 1'b1;
          r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
      end

      assign dout  = r_mem[r_rp];
      assign empty = (r_cnt == '0);
      assign full  = (r_cnt == W_DEPTH);
    end
  endgenerate

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with bus-readable buffer and W1C status.
// Build option: UART_RX_FIFO_EN (8-entry FIFO instead of one byte).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVIDER = BAUD_DIVIDER_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam logic [19:0] W_BIT  = 20'(BAUD_DIVIDER);
  localparam logic [19:0] W_HALF = 20'(BAUD_DIVIDER >> 1);
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic           r_sync1;
  logic           r_rxs;
  uart_rx_state_t r_state;
  logic [19:0]    r_timer;
  logic [3:0]     r_bitcnt;
  logic [7:0]     r_shift;
  logic           r_rdy;
  logic [31:0]    r_rdata;
  logic           r_ovr;
  logic           r_ferr;

  logic        w_stop_hit;
  logic        w_push;
  logic        w_ferr_set;
  logic        w_access;
  logic        w_is_stat;
  logic        w_wr;
  logic        w_pop;
  logic        w_clr_ovr;
  logic        w_clr_fe;
  logic        w_ovr_set;
  logic        w_empty;
  logic        w_full;
  logic [7:0]  w_dout;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{mem_instr, mem_wdata[31:3], mem_wdata[0],
                      mem_addr[31:3], mem_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= serialIn;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_timer  <= 20'd0;
      r_bitcnt <= 4'd0;
      r_shift  <= 8'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (!r_rxs) begin
          r_state <= ST_START;
          r_timer <= 20'd0;
        end
        ST_START: if (r_timer == W_HALF) begin
          r_timer  <= 20'd0;
          r_bitcnt <= 4'd0;
          r_state  <= r_rxs ? ST_IDLE : ST_DATA;
        end else r_timer <= r_timer + 20'd1;
        ST_DATA: if (r_timer == W_BIT) begin
          r_shift  <= {r_rxs, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
          r_timer  <= 20'd0;
          if (r_bitcnt == 4'd7) r_state <= ST_STOP;
        end else r_timer <= r_timer + 20'd1;
        ST_STOP: if (r_timer == W_BIT) begin
          r_timer <= 20'd0;
          r_state <= r_rxs ? ST_IDLE : ST_WAIT_HIGH;
        end else r_timer <= r_timer + 20'd1;
        ST_WAIT_HIGH: if (r_rxs) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_stop_hit = (r_state == ST_STOP) && (r_timer == W_BIT);
  assign w_push     = w_stop_hit & r_rxs;
  assign w_ferr_set = w_stop_hit & ~r_rxs;

  // Side effects fire only on the first cycle of a transaction.
  assign w_access  = mem_valid & enable & ~r_rdy;
  assign w_is_stat = (mem_addr[2] == UART_REG_STATUS[2]);
  assign w_wr      = |mem_wstrb;
  assign w_pop     = w_access & ~w_wr & ~w_is_stat & ~w_empty;
  assign w_clr_ovr = w_access & w_wr & w_is_stat & mem_wdata[ST_OVERRUN];
  assign w_clr_fe  = w_access & w_wr & w_is_stat & mem_wdata[ST_FRAMEERR];
  assign w_ovr_set = w_push & w_full & ~w_pop;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (w_pop),
    .din    (r_shift),
    .dout   (w_dout),
    .empty  (w_empty),
    .full   (w_full)
  );

  always_comb begin
    w_rdata = 32'd0;
    unique case (1'b1)
      w_is_stat: begin
        w_rdata[ST_AVAIL]    = ~w_empty;
        w_rdata[ST_OVERRUN]  = r_ovr;
        w_rdata[ST_FRAMEERR] = r_ferr;
      end
      default: w_rdata = {23'd0, ~w_empty, w_dout};
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdy   <= 1'b0;
      r_rdata <= 32'd0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rdy <= mem_valid & enable;
      if (w_access) r_rdata <= w_rdata;
      r_ovr  <= (r_ovr & ~w_clr_ovr) | w_ovr_set;
      r_ferr <= (r_ferr & ~w_clr_fe) | w_ferr_set;
    end
  end

  assign mem_ready = enable ? r_rdy   : 1'bz;
  assign mem_rdata = enable ? r_rdata : 32'bz;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level byte/flag model
// plus a per-cycle compare of the bus handshake and read data.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD = 15;
  localparam int P  = BD + 1;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_addr = 32'd0;
  logic        serialIn = 1'b1;
  wire         mem_ready;
  wire  [31:0] mem_rdata;

  uart_rx #(.BAUD_DIVIDER(BD)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit go = 1'b0;

  logic [7:0]  m_q[$];
  logic        m_ovr;
  logic        m_fe;
  logic [7:0]  m_last;
  bit          e_chk[$];
  logic [31:0] e_dat[$];
  logic [31:0] e_msk[$];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (go) begin
      if (e_chk.size() != 0) begin
        vectors++;
        if (mem_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready: got %b want 1 at %0t", mem_ready, $time);
        end
        if (e_chk[0]) begin
          vectors++;
          if ((mem_rdata & e_msk[0]) !== (e_dat[0] & e_msk[0])) begin
            errors++;
            $display("FAIL rdata: got %h want %h at %0t",
                     mem_rdata, e_dat[0], $time);
          end
        end
        void'(e_chk.pop_front());
        void'(e_dat.pop_front());
        void'(e_msk.pop_front());
      end else begin
        vectors++;
        if (mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL idle_ready: got %b want 0 at %0t", mem_ready, $time);
        end
      end
    end
  end

  task automatic model_clear();
    m_q.delete();
    m_ovr  = 1'b0;
    m_fe   = 1'b0;
    m_last = 8'd0;
  endtask

  task automatic frame_done(input logic [7:0] b, input logic stop);
    if (!stop) m_fe = 1'b1;
    else if (m_q.size() == DEPTH) m_ovr = 1'b1;
    else begin
      m_q.push_back(b);
      m_last = b;
    end
  endtask

  // mode 0: model value; 1: literal, model pinned to it; 2: literal only
  task automatic bus_start(input logic [31:0] addr, input logic [3:0] ws,
                           input logic [31:0] wd, input int mode,
                           input logic [31:0] lit);
    logic [31:0] m;
    logic [31:0] msk;
    logic        av;
    m   = 32'd0;
    msk = '1;
    if (mode != 2) begin
      av = (m_q.size() != 0);
      if (addr[2]) begin
        m = {29'd0, m_fe, m_ovr, av};
        if (ws != 0) begin
          if (wd[1]) m_ovr = 1'b0;
          if (wd[2]) m_fe = 1'b0;
        end
      end else begin
        m = {23'd0, av, av ? m_q[0] : m_last};
        if (DEPTH > 1 && !av) msk = 32'hFFFF_FF00;
        if (ws == 0 && av) void'(m_q.pop_front());
      end
    end
    if (mode == 1 && m !== lit) begin
      errors++;
      $display("FAIL model_pin: got %h want %h", m, lit);
    end
    mem_addr  = addr;
    mem_wstrb = ws;
    mem_wdata = wd;
    mem_valid = 1'b1;
    e_chk.push_back(ws == 0);
    e_dat.push_back(mode == 0 ? m : lit);
    e_msk.push_back(msk);
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] ws,
                     input logic [31:0] wd, input int mode,
                     input logic [31:0] lit);
    bus_start(addr, ws, wd, mode, lit);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'd0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rd_at, input logic [31:0] rd_addr,
                            input int mode, input logic [31:0] lit);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10 * P; i++) begin
      serialIn = fr[i / P];
      if (i == rd_at) bus_start(rd_addr, 4'd0, 32'd0, mode, lit);
      if (i == rd_at + 1) mem_valid = 1'b0;
      @(negedge clk);
    end
    frame_done(b, stop);
  endtask

  task automatic idle(input int n);
    serialIn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    go = 1'b1;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    idle(4);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);

    // single byte; status one cycle after the stop sample
    send_frame(8'hA5, 1'b1, 155, UART_REG_STATUS, 2, 32'h1);
    idle(4);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h1);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h1A5);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h0A5);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 0, 32'h0);

    // glitch
    serialIn = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);

    // framing error followed by break
    send_frame(8'h3C, 1'b0, -5, 32'd0, 0, 32'd0);
    repeat (40) @(negedge clk);
    idle(20);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h4);
    bus(UART_REG_DATA, 4'd0, 32'd0, 0, 32'h0);
    send_frame(8'h55, 1'b1, -5, 32'd0, 0, 32'd0);
    idle(4);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h5);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h155);
    bus(UART_REG_STATUS, 4'hF, 32'h4, 0, 32'h0);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);

    // overrun
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'(8'h11 * (i + 1)), 1'b1, -5, 32'd0, 0, 32'd0);
    idle(4);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h3);
    for (int i = 0; i < DEPTH; i++)
      bus(UART_REG_DATA, 4'd0, 32'd0, 1,
          {23'd0, 1'b1, 8'(8'h11 * (i + 1))});
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h2);
    bus(UART_REG_STATUS, 4'h1, 32'h2, 0, 32'h0);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);

    // pop in the same cycle as the stop sample of a new byte
    for (int i = 0; i < DEPTH; i++)
      send_frame(8'(8'hC3 + i), 1'b1, -5, 32'd0, 0, 32'd0);
    send_frame(8'h96, 1'b1, 154, UART_REG_DATA, 1, 32'h1C3);
    idle(4);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h1);
    for (int i = 1; i < DEPTH; i++)
      bus(UART_REG_DATA, 4'd0, 32'd0, 0, 32'h0);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h196);

    // reset in the middle of data bit 4
    send_frame(8'h77, 1'b1, -5, 32'd0, 0, 32'd0);
    serialIn = 1'b0;
    repeat (P) @(negedge clk);
    serialIn = 1'b1;
    repeat (4 * P + P / 2) @(negedge clk);
    resetn = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
    check("mid_rst_rdata", mem_rdata, 32'd0);
    idle(4 * P);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h0);
    send_frame(8'h12, 1'b1, -5, 32'd0, 0, 32'd0);
    idle(4);
    bus(UART_REG_DATA, 4'd0, 32'd0, 1, 32'h112);
    bus(UART_REG_STATUS, 4'd0, 32'd0, 1, 32'h0);

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Simple UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first. Two-flop input synchroniser, mid-bit sampling, and a receive buffer read over the same memory-mapped bus as the transmitter. Sits beside the transmitter on the peripheral bus, selected by its own `enable` decode. Default bit timing matches the transmitter so the pair interoperates.

## Interface
- `BAUD_DIVIDER`, 1301: bit period is `BAUD_DIVIDER+1` clocks, the same convention as the transmitter; minimum value 3.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `enable` input 1: address-decode select for this peripheral.
- `mem_valid` input 1: bus request.
- `mem_ready` output 1: `enable ? rdy : 'bz`.
- `mem_instr` input 1: ignored.
- `mem_wstrb` input 4: zero means read; any nonzero bit means write.
- `mem_wdata` input 32: write data; used only for status clears.
- `mem_addr` input 32: only bit 2 is decoded.
- `mem_rdata` output 32: `enable ? rdata_q : 'bz`.
- `serialIn` input 1: asynchronous serial line; idles high.

## Operation
- **Synchroniser:** `serialIn` passes through two flops, both reset to 1. Everything downstream uses the second flop, `rxs`.
- **Receive FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH. It uses a bit timer `timer[19:0]` and a bit counter `bitCount[3:0]`.
  - IDLE → START when `rxs==0`, with `timer=0`.
  - START: at `timer==BAUD_DIVIDER>>1`, sample `rxs`.
    - If 1 (glitch), return to IDLE.
    - If 0, go to DATA with `timer=0` and `bitCount=0`.
  - DATA: at `timer==BAUD_DIVIDER`, shift `rxs` into bit 7 of `shifter` (right shift), increment `bitCount`, and set `timer=0`. After the 8th bit, go to STOP.
  - STOP: at `timer==BAUD_DIVIDER`, sample `rxs`.
    - If 1, push `shifter` and go to IDLE.
    - If 0, set `frameErr`, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH → IDLE when `rxs==1`. This prevents a break condition from producing repeated 0x00 bytes.
- **Receive buffer:** depth 1 (see Configuration). A push when the buffer is full sets `overrun` and drops the new byte; buffer contents are unchanged.
- **Register map**, selected by `mem_addr[2]`:
  - Address 0 is DATA.
    - Read returns `{23'b0, avail, byte}`.
    - A read with `avail=1` pops one entry.
    - Writes are ignored.
  - Address 4 is STATUS.
    - Read returns `{29'b0, frameErr, overrun, avail}`.
    - A write with any nonzero strobe clears `overrun` if `wdata[1]` is set and `frameErr` if `wdata[2]` is set (write-1-to-clear).
- **Bus handshake:**
  - `rdy` is set to 1 on every cycle with `mem_valid&enable`, else 0, so it follows one cycle behind.
  - `rdata_q` is loaded on the same cycle that `rdy` is set.
  - Side effects (pop, W1C) occur exactly once per transaction, on the first cycle: `mem_valid&enable&!rdy`.
- **Same-cycle events:**
  - Push and pop together: both take effect and the occupancy is unchanged. When the buffer is full, the pop frees space first, so no overrun.
  - A W1C clear and a new error in the same cycle: the set wins.
- **Reset values:**
  - Outputs: `rdy=0`, `rdata_q=0`.
  - Internal state: FSM=IDLE, `timer=0`, `bitCount=0`, `shifter=0`, buffer empty, `overrun=0`, `frameErr=0`.
  - The driven outputs (`mem_ready`, `mem_rdata`) therefore reset to 0 when `enable=1`.
  - Reset mid-frame abandons the frame. After release, the receiver waits for the next falling edge; if the line is low at that point it treats it as a start bit.

## Timing
- Let t0 be the first cycle with `rxs==0`. Pin to `rxs` latency is 2 clocks.
- Sample points relative to t0, with H=`BAUD_DIVIDER>>1` and P=`BAUD_DIVIDER+1`:
  - start bit: t0+1+H
  - data bit i (0..7): t0+1+H+(i+1)·P
  - stop bit: t0+1+H+9·P
- `avail` reads 1 from the cycle after the stop sample.
- A bus read returns `mem_ready=1` one cycle after `mem_valid`, with data valid in the same cycle.
- A back-to-back frame is accepted: after the stop sample, IDLE detects the next start edge immediately.

## Configuration
- `UART_RX_FIFO_EN`
  - Defined: the receive buffer is an 8-entry circular FIFO with 3-bit pointers and a 4-bit count. `avail` means count≠0; overrun occurs only when the count is 8.
  - Undefined: the buffer is a single holding register plus a full flag.
- The register map and handshake are identical in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum `uart_rx_state_t`.
  - Register offsets `UART_REG_DATA=0` and `UART_REG_STATUS=4`.
  - Status bit indices `ST_AVAIL=0`, `ST_OVERRUN=1`, `ST_FRAMEERR=2`.
  - Default `BAUD_DIVIDER`.
- **Sub-module `uart_rx_fifo`** (parameter `DEPTH`: 1 or 8, chosen by the macro). Ports: `push`, `pop`, `din[7:0]`, `dout[7:0]`, `empty`, `full`. The top level contains the synchroniser, FSM and bus logic.

## Test plan
Use `BAUD_DIVIDER=15` (P=16) in the bench.
1. **Single byte:** drive frame 0xA5 → one bus read of address 4 returns 0x1; a read of address 0 returns 0x1A5; a second read of address 0 returns 0x0A5 with `avail=0`.
2. **Glitch:** drive a 3-clock low pulse on an idle line → FSM returns to IDLE; `avail` stays 0 and no error is flagged.
3. **Framing error:** drive 0x3C with stop bit 0, then hold the line low for 40 clocks → status reads 0x4, no byte is pushed, and exactly one error occurs. A following valid 0x55 is received. Writing 0x4 to address 4 clears the error.
4. **Overrun:** send two bytes without reading (depth 1), or nine bytes (FIFO build) → status reads 0x3. The first byte(s) are retained in order and the extra byte is lost.
5. **Pop/push collision:** with the buffer full, issue a DATA read in the same cycle as a stop sample → no overrun; the new byte is readable next.
6. **Reset mid-frame:** assert `resetn` low during data bit 4 of 0xFF → all state returns to reset values; the next 0x12 frame is received correctly.
